// File: rtl/msrh_l2_req_credit_arbiter.sv
// rtl/msrh_l2_req_credit_arbiter.sv - N-to-1 L2 request arbiter with RR/hpri, read credits, and response routing
module msrh_l2_req_credit_arbiter #(
  parameter  int REQ_PORT_NUM = 2,
  parameter  int ADDR_W       = 56,
  parameter  int DATA_W       = 512,
  parameter  int TAG_W        = 4,
  parameter  int MAX_OUTST    = 4,
  localparam int PORT_W       = (REQ_PORT_NUM > 1) ? $clog2(REQ_PORT_NUM) : 1,
  localparam int CNT_W        = $clog2(MAX_OUTST + 1),
  localparam int BE_W         = DATA_W / 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,

  input  logic                      i_req_valid [REQ_PORT_NUM],
  output logic                      o_req_ready [REQ_PORT_NUM],
  input  logic                      i_req_hpri  [REQ_PORT_NUM],
  input  logic [1:0]                i_req_cmd   [REQ_PORT_NUM],
  input  logic [ADDR_W-1:0]         i_req_addr  [REQ_PORT_NUM],
  input  logic [TAG_W-1:0]          i_req_tag   [REQ_PORT_NUM],
  input  logic [DATA_W-1:0]         i_req_data  [REQ_PORT_NUM],
  input  logic [BE_W-1:0]           i_req_be    [REQ_PORT_NUM],

  output logic                      o_l2_req_valid,
  input  logic                      i_l2_req_ready,
  output logic [1:0]                o_l2_req_cmd,
  output logic [ADDR_W-1:0]         o_l2_req_addr,
  output logic [DATA_W-1:0]         o_l2_req_data,
  output logic [BE_W-1:0]           o_l2_req_be,
  output logic [PORT_W+TAG_W-1:0]   o_l2_req_tag,

  input  logic                      i_l2_resp_valid,
  input  logic [PORT_W+TAG_W-1:0]   i_l2_resp_tag,
  input  logic [DATA_W-1:0]         i_l2_resp_data,

  output logic                      o_resp_valid [REQ_PORT_NUM],
  output logic [TAG_W-1:0]          o_resp_tag,
  output logic [DATA_W-1:0]         o_resp_data,
  output logic [CNT_W-1:0]          o_outst_cnt [REQ_PORT_NUM]
);

  localparam logic [1:0]       CMD_RD  = 2'd0;
  localparam logic [1:0]       CMD_WR  = 2'd1;
  localparam logic [1:0]       CMD_RSV = 2'd3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  // Registered state
  logic                    slot_valid_q, slot_valid_d;
  logic [1:0]              slot_cmd_q,   slot_cmd_d;
  logic [ADDR_W-1:0]       slot_addr_q,  slot_addr_d;
  logic [DATA_W-1:0]       slot_data_q,  slot_data_d;
  logic [BE_W-1:0]         slot_be_q,    slot_be_d;
  logic [PORT_W+TAG_W-1:0] slot_tag_q,   slot_tag_d;
  logic [PORT_W-1:0]       rr_ptr_q,     rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q         [REQ_PORT_NUM];
  logic [CNT_W-1:0]        cnt_d         [REQ_PORT_NUM];
  logic                    resp_valid_q  [REQ_PORT_NUM];
  logic                    resp_valid_d  [REQ_PORT_NUM];
  logic [TAG_W-1:0]        resp_tag_q,   resp_tag_d;
  logic [DATA_W-1:0]       resp_data_q,  resp_data_d;

  // Combinational arbitration signals
  logic                    slot_load;
  logic [REQ_PORT_NUM-1:0] elig;
  logic [REQ_PORT_NUM-1:0] elig_hpri;
  logic [REQ_PORT_NUM-1:0] cand;
  logic                    grant_vld;
  logic [PORT_W-1:0]       grant_idx;
  logic [PORT_W-1:0]       rsp_port;
  logic                    rsp_in_range;

  // Port index k steps after ptr, wrapped into [0, REQ_PORT_NUM)
  function automatic int rr_idx(input logic [PORT_W-1:0] ptr, input int k);
    int sum;
    sum = int'(ptr) + k;
    return (sum >= REQ_PORT_NUM) ? (sum - REQ_PORT_NUM) : sum;
  endfunction

  assign slot_load    = !slot_valid_q || i_l2_req_ready;
  assign rsp_port     = i_l2_resp_tag[PORT_W+TAG_W-1:TAG_W];
  assign rsp_in_range = ({1'b0, rsp_port} < (PORT_W+1)'(REQ_PORT_NUM));

  // Eligibility: reads need a free credit, writes/evicts always eligible
  always_comb begin
    elig      = '0;
    elig_hpri = '0;
    for (int p = 0; p < REQ_PORT_NUM; p++) begin
      elig[p]      = i_req_valid[p] && ((i_req_cmd[p] != CMD_RD) || (cnt_q[p] < MAX_CNT));
      elig_hpri[p] = elig[p] && i_req_hpri[p];
    end
    cand = (|elig_hpri) ? elig_hpri : elig;
  end

  // Round-robin search from rr_ptr over the candidate class
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (slot_load) begin
      for (int k = 0; k < REQ_PORT_NUM; k++) begin
        if (!grant_vld && cand[rr_idx(rr_ptr_q, k)]) begin
          grant_vld = 1'b1;
          grant_idx = PORT_W'(rr_idx(rr_ptr_q, k));
        end
      end
    end
  end

  // Same-cycle accept strobe, forced low while in reset
  always_comb begin
    for (int p = 0; p < REQ_PORT_NUM; p++) begin
      o_req_ready[p] = i_reset_n && grant_vld && (grant_idx == PORT_W'(p));
    end
  end

  // Output slot and round-robin pointer next state
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_cmd_d   = slot_cmd_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    slot_be_d    = slot_be_q;
    slot_tag_d   = slot_tag_q;
    rr_ptr_d     = rr_ptr_q;
    if (slot_load) begin
      slot_valid_d = grant_vld;
    end
    if (grant_vld) begin
      slot_cmd_d  = (i_req_cmd[grant_idx] == CMD_RSV) ? CMD_WR : i_req_cmd[grant_idx];
      slot_addr_d = i_req_addr[grant_idx];
      slot_data_d = i_req_data[grant_idx];
      slot_be_d   = i_req_be[grant_idx];
      slot_tag_d  = {grant_idx, i_req_tag[grant_idx]};
      rr_ptr_d    = (int'(grant_idx) == REQ_PORT_NUM - 1) ? '0 : grant_idx + PORT_W'(1);
    end
  end

  // Credit counters and registered response routing next state
  always_comb begin
    resp_tag_d  = resp_tag_q;
    resp_data_d = resp_data_q;
    if (i_l2_resp_valid && rsp_in_range) begin
      resp_tag_d  = i_l2_resp_tag[TAG_W-1:0];
      resp_data_d = i_l2_resp_data;
    end
    for (int p = 0; p < REQ_PORT_NUM; p++) begin
      logic inc, hit, dec;
      inc = o_req_ready[p] && (i_req_cmd[p] == CMD_RD);
      hit = i_l2_resp_valid && rsp_in_range && (rsp_port == PORT_W'(p));
      dec = hit && (cnt_q[p] != '0);
      resp_valid_d[p] = hit;
      cnt_d[p]        = cnt_q[p];
      if (inc && !dec) begin
        cnt_d[p] = cnt_q[p] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[p] = cnt_q[p] - CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_valid_q <= 1'b0;
      slot_cmd_q   <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      slot_be_q    <= '0;
      slot_tag_q   <= '0;
      rr_ptr_q     <= '0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      for (int p = 0; p < REQ_PORT_NUM; p++) begin
        cnt_q[p]        <= '0;
        resp_valid_q[p] <= 1'b0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_cmd_q   <= slot_cmd_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      slot_be_q    <= slot_be_d;
      slot_tag_q   <= slot_tag_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      for (int p = 0; p < REQ_PORT_NUM; p++) begin
        cnt_q[p]        <= cnt_d[p];
        resp_valid_q[p] <= resp_valid_d[p];
      end
    end
  end

  assign o_l2_req_valid = slot_valid_q;
  assign o_l2_req_cmd   = slot_cmd_q;
  assign o_l2_req_addr  = slot_addr_q;
  assign o_l2_req_data  = slot_data_q;
  assign o_l2_req_be    = slot_be_q;
  assign o_l2_req_tag   = slot_tag_q;
  assign o_resp_tag     = resp_tag_q;
  assign o_resp_data    = resp_data_q;

  // Expose per-port counters and routed response strobes
  always_comb begin
    for (int p = 0; p < REQ_PORT_NUM; p++) begin
      o_outst_cnt[p]  = cnt_q[p];
      o_resp_valid[p] = resp_valid_q[p];
    end
  end

`ifdef SIMULATION
  // Illegal responses: unknown port or no read outstanding on that port
  always_ff @(posedge i_clk) begin
    if (i_reset_n && i_l2_resp_valid) begin
      if (!rsp_in_range) begin
        $fatal(1, "l2 response port %0d out of range", rsp_port);
      end else if (cnt_q[rsp_port] == '0) begin
        $fatal(1, "l2 response to port %0d with no outstanding read", rsp_port);
      end
    end
  end
`endif

endmodule

// File: tb/tb_msrh_l2_req_credit_arbiter.sv
// tb/tb_msrh_l2_req_credit_arbiter.sv - directed table-driven bench for msrh_l2_req_credit_arbiter
module tb_msrh_l2_req_credit_arbiter;

  localparam int N     = 3;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int MAXO  = 2;
  localparam int PW    = 2;
  localparam int CW    = 2;
  localparam int BW    = DW / 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid [N];
  logic           req_ready [N];
  logic           req_hpri  [N];
  logic [1:0]     req_cmd   [N];
  logic [AW-1:0]  req_addr  [N];
  logic [TW-1:0]  req_tag   [N];
  logic [DW-1:0]  req_data  [N];
  logic [BW-1:0]  req_be    [N];
  logic           l2_valid;
  logic           l2_ready;
  logic [1:0]     l2_cmd;
  logic [AW-1:0]  l2_addr;
  logic [DW-1:0]  l2_data;
  logic [BW-1:0]  l2_be;
  logic [PW+TW-1:0] l2_tag;
  logic           rsp_in_valid;
  logic [PW+TW-1:0] rsp_in_tag;
  logic [DW-1:0]  rsp_in_data;
  logic           resp_valid [N];
  logic [TW-1:0]  resp_tag;
  logic [DW-1:0]  resp_data;
  logic [CW-1:0]  outst [N];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  msrh_l2_req_credit_arbiter #(
    .REQ_PORT_NUM(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .MAX_OUTST(MAXO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_hpri(req_hpri),
    .i_req_cmd(req_cmd), .i_req_addr(req_addr), .i_req_tag(req_tag),
    .i_req_data(req_data), .i_req_be(req_be),
    .o_l2_req_valid(l2_valid), .i_l2_req_ready(l2_ready),
    .o_l2_req_cmd(l2_cmd), .o_l2_req_addr(l2_addr), .o_l2_req_data(l2_data),
    .o_l2_req_be(l2_be), .o_l2_req_tag(l2_tag),
    .i_l2_resp_valid(rsp_in_valid), .i_l2_resp_tag(rsp_in_tag), .i_l2_resp_data(rsp_in_data),
    .o_resp_valid(resp_valid), .o_resp_tag(resp_tag), .o_resp_data(resp_data),
    .o_outst_cnt(outst)
  );

  typedef struct {
    logic [2:0] vld;
    logic [2:0] hpri;
    logic [2:0] wr;
    logic       rdy;
    logic       rspv;
    logic [5:0] rt;
    logic [2:0] e_ready;
    logic       e_l2v;
    logic [5:0] e_l2tag;
    logic [5:0] e_cnt;
    logic [2:0] e_rspv;
    logic [3:0] e_rtag;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [2:0] ready_mask();
    return {req_ready[2], req_ready[1], req_ready[0]};
  endfunction

  function automatic logic [5:0] cnt_pack();
    return {outst[2], outst[1], outst[0]};
  endfunction

  function automatic logic [2:0] rspv_mask();
    return {resp_valid[2], resp_valid[1], resp_valid[0]};
  endfunction

  task automatic set_inputs(input logic [2:0] vld, input logic [2:0] hpri, input logic [2:0] wr,
                            input logic rdy, input logic rspv, input logic [5:0] rt);
    for (int p = 0; p < N; p++) begin
      req_valid[p] = vld[p];
      req_hpri[p]  = hpri[p];
      req_cmd[p]   = wr[p] ? 2'd1 : 2'd0;
    end
    l2_ready     = rdy;
    rsp_in_valid = rspv;
    rsp_in_tag   = rt;
    rsp_in_data  = 32'hD000_0000 | 32'(rt);
  endtask

  // One cycle: drive after negedge, check comb ready, then registered outputs after posedge
  task automatic step(input string nm, input vec_t v);
    logic [1:0] g;
    set_inputs(v.vld, v.hpri, v.wr, v.rdy, v.rspv, v.rt);
    #1;
    check({nm, " ready"}, 64'(ready_mask()), 64'(v.e_ready));
    @(posedge clk);
    #1;
    g = v.e_l2tag[5:4];
    check({nm, " l2_valid"}, 64'(l2_valid), 64'(v.e_l2v));
    if (v.e_l2v) begin
      check({nm, " l2_tag"},  64'(l2_tag),  64'(v.e_l2tag));
      check({nm, " l2_addr"}, 64'(l2_addr), 64'(16'h1000 + 16'(g)));
      check({nm, " l2_data"}, 64'(l2_data), 64'(32'hDA7A_0000 + 32'(g)));
      check({nm, " l2_cmd"},  64'(l2_cmd),  64'(v.wr[g] ? 2'd1 : 2'd0));
    end
    check({nm, " cnt"},  64'(cnt_pack()),  64'(v.e_cnt));
    check({nm, " rspv"}, 64'(rspv_mask()), 64'(v.e_rspv));
    if (v.e_rspv != 3'b000) begin
      check({nm, " rsp_tag"},  64'(resp_tag),  64'(v.e_rtag));
      check({nm, " rsp_data"}, 64'(resp_data), 64'(32'hD000_0000 | 32'(v.rt)));
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] hpri, input logic [2:0] wr,
                              input logic rdy, input logic rspv, input logic [5:0] rt,
                              input logic [2:0] e_ready, input logic e_l2v, input logic [5:0] e_l2tag,
                              input logic [5:0] e_cnt, input logic [2:0] e_rspv, input logic [3:0] e_rtag);
    vec_t v;
    v.vld = vld; v.hpri = hpri; v.wr = wr; v.rdy = rdy; v.rspv = rspv; v.rt = rt;
    v.e_ready = e_ready; v.e_l2v = e_l2v; v.e_l2tag = e_l2tag; v.e_cnt = e_cnt;
    v.e_rspv = e_rspv; v.e_rtag = e_rtag;
    return v;
  endfunction

  initial begin
    // Port p: addr 0x1000+p, data 0xDA7A0000+p, tag 0xA+p
    for (int p = 0; p < N; p++) begin
      req_addr[p] = 16'h1000 + 16'(p);
      req_data[p] = 32'hDA7A_0000 + 32'(p);
      req_tag[p]  = 4'hA + 4'(p);
      req_be[p]   = 4'hF;
    end
    set_inputs(3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 6'h00);

    // Round-robin over three RD ports until every port hits its credit limit
    tbl[0]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b00_00_01, 3'b000, 4'h0);
    tbl[1]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b00_01_01, 3'b000, 4'h0);
    tbl[2]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b100, 1, 6'h2C, 6'b01_01_01, 3'b000, 4'h0);
    tbl[3]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b01_01_10, 3'b000, 4'h0);
    tbl[4]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b01_10_10, 3'b000, 4'h0);
    tbl[5]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b100, 1, 6'h2C, 6'b10_10_10, 3'b000, 4'h0);
    tbl[6]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b000, 0, 6'h00, 6'b10_10_10, 3'b000, 4'h0);
    // Response to port 1 frees a credit, usable next cycle
    tbl[7]  = mk(3'b111, 3'b000, 3'b000, 1, 1, 6'h15, 3'b000, 0, 6'h00, 6'b10_01_10, 3'b010, 4'h5);
    tbl[8]  = mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b10_10_10, 3'b000, 4'h0);
    tbl[9]  = mk(3'b111, 3'b000, 3'b000, 1, 1, 6'h09, 3'b000, 0, 6'h00, 6'b10_10_01, 3'b001, 4'h9);
    // High priority port 1 wins repeatedly over port 0
    tbl[10] = mk(3'b011, 3'b010, 3'b011, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b10_10_01, 3'b000, 4'h0);
    tbl[11] = mk(3'b011, 3'b010, 3'b011, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b10_10_01, 3'b000, 4'h0);
    tbl[12] = mk(3'b001, 3'b000, 3'b001, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_01, 3'b000, 4'h0);
    // Round-robin among two hpri ports, skipping the normal one
    tbl[13] = mk(3'b111, 3'b101, 3'b111, 1, 0, 6'h00, 3'b100, 1, 6'h2C, 6'b10_10_01, 3'b000, 4'h0);
    tbl[14] = mk(3'b111, 3'b101, 3'b111, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_01, 3'b000, 4'h0);
    tbl[15] = mk(3'b000, 3'b000, 3'b000, 1, 0, 6'h00, 3'b000, 0, 6'h00, 6'b10_10_01, 3'b000, 4'h0);

    // Reset state with requests pending
    repeat (2) @(posedge clk);
    #1;
    check("reset ready",    64'(ready_mask()), 64'(0));
    check("reset l2_valid", 64'(l2_valid), 64'(0));
    check("reset l2_tag",   64'(l2_tag),   64'(0));
    check("reset l2_addr",  64'(l2_addr),  64'(0));
    check("reset l2_data",  64'(l2_data),  64'(0));
    check("reset cnt",      64'(cnt_pack()), 64'(0));
    check("reset rspv",     64'(rspv_mask()), 64'(0));
    check("reset rsp_tag",  64'(resp_tag), 64'(0));
    check("reset rsp_data", 64'(resp_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Stall: slot loaded while downstream not ready, then frozen for 5 cycles
    step("stall_load", mk(3'b001, 3'b000, 3'b001, 0, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_01, 3'b000, 4'h0));
    req_addr[0] = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("stall%0d", i), mk(3'b111, 3'b000, 3'b111, 0, 0, 6'h00, 3'b000, 1, 6'h0A, 6'b10_10_01, 3'b000, 4'h0));
    end
    req_addr[0] = 16'h1000;
    step("stall_release", mk(3'b111, 3'b000, 3'b111, 1, 0, 6'h00, 3'b010, 1, 6'h1B, 6'b10_10_01, 3'b000, 4'h0));
    step("drain", mk(3'b000, 3'b000, 3'b000, 1, 0, 6'h00, 3'b000, 0, 6'h00, 6'b10_10_01, 3'b000, 4'h0));

    // Credit limit on port 0: RD blocked at the limit, WR still passes, response frees credit
    step("cred_rd",   mk(3'b001, 3'b000, 3'b000, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_10, 3'b000, 4'h0));
    step("cred_blk",  mk(3'b001, 3'b000, 3'b000, 1, 0, 6'h00, 3'b000, 0, 6'h00, 6'b10_10_10, 3'b000, 4'h0));
    step("cred_wr",   mk(3'b001, 3'b000, 3'b001, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_10, 3'b000, 4'h0));
    step("cred_rsp",  mk(3'b001, 3'b000, 3'b000, 1, 1, 6'h03, 3'b000, 0, 6'h00, 6'b10_10_01, 3'b001, 4'h3));
    step("cred_next", mk(3'b001, 3'b000, 3'b000, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b10_10_10, 3'b000, 4'h0));

    // Grant and response on port 2 in the same cycle with one outstanding
    step("same_pre", mk(3'b000, 3'b000, 3'b000, 1, 1, 6'h27, 3'b000, 0, 6'h00, 6'b01_10_10, 3'b100, 4'h7));
    step("same_cyc", mk(3'b100, 3'b000, 3'b000, 1, 1, 6'h26, 3'b100, 1, 6'h2C, 6'b01_10_10, 3'b100, 4'h6));
    step("hold_full", mk(3'b000, 3'b000, 3'b000, 0, 0, 6'h00, 3'b000, 1, 6'h2C, 6'b01_10_10, 3'b000, 4'h0));

    // Asynchronous reset with the slot full and counters at the limit
    set_inputs(3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 6'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst l2_valid", 64'(l2_valid), 64'(0));
    check("mid_rst cnt",      64'(cnt_pack()), 64'(0));
    check("mid_rst ready",    64'(ready_mask()), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", mk(3'b111, 3'b000, 3'b000, 1, 0, 6'h00, 3'b001, 1, 6'h0A, 6'b00_00_01, 3'b000, 4'h0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
